modulo_product: RTL and testbench
=================================

// Module: modulo_product
// PURPOSE
//   Iterative modular multiplier: o_prod = (i_a * i_b) mod i_n, one multiplier bit per cycle.
//   Pre-stage of the RSA datapath, directly upstream of the Montgomery multiplier.
//   With i_b = 2^256 it produces a*2^256 mod n, moving an operand into the Montgomery domain
//   before it is handed to the Montgomery stage.
// PARAMETERS
//   WIDTH    256  width of modulus, operand a and result
//   B_WIDTH  257  width of multiplier b; must hold 2^WIDTH
// PORTS
//   i_clk    in   1        clock, rising edge
//   i_rst_n  in   1        asynchronous reset, active low
//   i_start  in   1        start request; sampled only in IDLE
//   i_n      in   WIDTH    modulus; precondition 1 < n
//   i_a      in   WIDTH    multiplicand; precondition a < n
//   i_b      in   B_WIDTH  multiplier, any value
//   o_busy   out  1        high while in CALC
//   o_prod   out  WIDTH    result; holds until the next completion
//   o_end    out  1        one-cycle done pulse; o_prod is valid in the same cycle
// BEHAVIOUR
//   Reset: async on i_rst_n low. State=IDLE; o_busy=0, o_end=0, o_prod=0; internal regs=0.
//   Reset mid-operation aborts immediately; no o_end is produced for the aborted job.
//   States:
//     IDLE: on i_start=1 at a clock edge:
//       - latch n, a, b
//       - t<=a, m<=0, cnt<=0
//       - go to CALC
//     CALC, each cycle, for bit i = cnt:
//       - m' = b[i] ? m+t : m; if m' >= n, m' -= n
//       - t' = 2t; if t' >= n, t' -= n
//       - compute in WIDTH+1 bits so m+t and 2t do not overflow (both < 2n)
//       - cnt <= cnt+1
//     When cnt == B_WIDTH-1, the same edge:
//       - writes final m' into o_prod
//       - sets o_end=1
//       - returns to IDLE
//   Latency: i_start sampled at edge E0 -> o_end high after edge E0+B_WIDTH.
//   o_end lasts exactly one cycle. Default latency is 257 cycles.
//   i_start while busy: ignored, and latched operands are unaffected.
//   Input changes while busy have no effect.
//   i_start high in the o_end cycle: state is already IDLE, so the new job is accepted at
//   the next edge. o_prod keeps the old result until that job ends.
//   Holding i_start high continuously starts back-to-back jobs; o_end pulses every
//   B_WIDTH+1 cycles.
//   Invariants: m < n and t < n after every iteration; o_prod < n.
// TESTING
//   1. n=11, a=5, b=7 -> o_prod=2; o_end exactly 257 cycles after the start edge;
//      o_busy high throughout.
//   2. n=2^256-189, a=2^255, b=2 -> o_prod=189 (checks the reduction carry in bit WIDTH).
//   3. a=0 or b=0 with n=1731 -> o_prod=0.
//      n=1731, a=1730, b=1 -> o_prod=1730.
//   4. n=1731, a=97, b=2^256 -> o_prod equals the golden-model value of 97*2^256 mod 1731;
//      that o_prod is then fed to the Montgomery stage.
//   5. Pulse i_start again at cycle 50 of a job with different operands -> ignored;
//      result matches the first operands.
//   6. Assert i_rst_n=0 at cycle 100 of a job -> outputs 0 immediately, no o_end.
//      Restart after reset -> correct result.

Source files
------------

// File: rtl/modulo_product_if.sv
// rtl/modulo_product_if.sv - start/operand/result bundle for the iterative modular multiplier
interface modulo_product_if #(
  parameter int WIDTH   = 256,
  parameter int B_WIDTH = 257
);
  logic               i_start;
  logic [WIDTH-1:0]   i_n;
  logic [WIDTH-1:0]   i_a;
  logic [B_WIDTH-1:0] i_b;
  logic               o_busy;
  logic [WIDTH-1:0]   o_prod;
  logic               o_end;

  modport master (
    output i_start, i_n, i_a, i_b,
    input  o_busy, o_prod, o_end
  );

  modport slave (
    input  i_start, i_n, i_a, i_b,
    output o_busy, o_prod, o_end
  );
endinterface

// File: rtl/modulo_product.sv
// rtl/modulo_product.sv - iterative (a * b) mod n, one multiplier bit per cycle, LSB first
module modulo_product #(
  parameter int WIDTH   = 256,
  parameter int B_WIDTH = 257
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  modulo_product_if.slave bus
);

  localparam int                CNT_W = $clog2(B_WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(B_WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic               end_q, end_d;

  // Both m+t and 2t are < 2n, so one extra bit and a single conditional subtract suffice.
  logic [WIDTH:0]     n_ext;
  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     t_dbl;
  logic [WIDTH:0]     m_red;
  logic [WIDTH:0]     t_red;
  logic [WIDTH-1:0]   m_next;
  logic [WIDTH-1:0]   t_next;

  always_comb begin
    n_ext  = {1'b0, n_q};
    m_sum  = b_q[cnt_q] ? ({1'b0, m_q} + {1'b0, t_q}) : {1'b0, m_q};
    t_dbl  = {t_q, 1'b0};
    m_red  = (m_sum >= n_ext) ? (m_sum - n_ext) : m_sum;
    t_red  = (t_dbl >= n_ext) ? (t_dbl - n_ext) : t_dbl;
    m_next = m_red[WIDTH-1:0];
    t_next = t_red[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t_d     = t_q;
    m_d     = m_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    end_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          n_d     = bus.i_n;
          t_d     = bus.i_a;
          b_d     = bus.i_b;
          m_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        m_d   = m_next;
        t_d   = t_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_d  = m_next;
          end_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t_q     <= t_d;
      m_q     <= m_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      end_q   <= end_d;
    end
  end

  assign bus.o_busy = (state_q == CALC);
  assign bus.o_prod = prod_q;
  assign bus.o_end  = end_q;

endmodule

// File: tb/tb_modulo_product.sv
// tb/tb_modulo_product.sv - directed-vector bench for modulo_product
module tb_modulo_product;

  localparam int WIDTH   = 256;
  localparam int B_WIDTH = 257;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modulo_product_if #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH)) bus();

  modulo_product #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic start_job(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] a,
                           input logic [B_WIDTH-1:0] b);
    @(negedge clk);
    bus.i_n     = n;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Counts edges after the current point until o_end is seen; -1 on timeout.
  task automatic wait_end(output int cycles, output bit busy_ok);
    bit done;
    done    = 1'b0;
    cycles  = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_end) begin
        cycles = i;
        done   = 1'b1;
      end else if (!bus.o_busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0;
    bus.i_n     = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_end !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", bus.o_end); end
    checks++; if (bus.o_prod !== '0) begin failures++; $display("FAIL reset_prod got=%0h exp=0", bus.o_prod); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit bok;
    start_job(256'd11, 256'd5, 257'd7);
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", bus.o_busy); end
    wait_end(cyc, bok);
    checks++; if (cyc !== 257) begin failures++; $display("FAIL basic_latency got=%0d exp=257", cyc); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy_held got=%b exp=1", bok); end
    checks++; if (bus.o_prod !== 256'd2) begin failures++; $display("FAIL basic_prod got=%0h exp=2", bus.o_prod); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", bus.o_busy); end
    @(posedge clk);
    #1;
    checks++; if (bus.o_end !== 1'b0) begin failures++; $display("FAIL basic_end_pulse got=%b exp=0", bus.o_end); end
    checks++; if (bus.o_prod !== 256'd2) begin failures++; $display("FAIL basic_prod_hold got=%0h exp=2", bus.o_prod); end
  endtask

  task automatic test_carry();
    int cyc; bit bok;
    logic [WIDTH-1:0] n_big;
    logic [WIDTH-1:0] a_big;
    n_big = 256'd0 - 256'd189;
    a_big = 256'd1 << 255;
    start_job(n_big, a_big, 257'd2);
    wait_end(cyc, bok);
    checks++; if (cyc !== 257) begin failures++; $display("FAIL carry_latency got=%0d exp=257", cyc); end
    checks++; if (bus.o_prod !== 256'd189) begin failures++; $display("FAIL carry_prod got=%0h exp=bd", bus.o_prod); end
  endtask

  task automatic test_zero_and_one();
    int cyc; bit bok;
    start_job(256'd1731, 256'd0, 257'd5);
    wait_end(cyc, bok);
    checks++; if (bus.o_prod !== 256'd0) begin failures++; $display("FAIL zero_a got=%0d exp=0", bus.o_prod); end
    start_job(256'd1731, 256'd7, 257'd0);
    wait_end(cyc, bok);
    checks++; if (bus.o_prod !== 256'd0) begin failures++; $display("FAIL zero_b got=%0d exp=0", bus.o_prod); end
    start_job(256'd1731, 256'd1730, 257'd1);
    wait_end(cyc, bok);
    checks++; if (bus.o_prod !== 256'd1730) begin failures++; $display("FAIL one_b got=%0d exp=1730", bus.o_prod); end
  endtask

  task automatic test_mont_domain();
    int cyc; bit bok;
    logic [B_WIDTH-1:0] r;
    r = 257'd1 << 256;
    start_job(256'd1731, 256'd97, r);
    wait_end(cyc, bok);
    // 2^256 mod 1731 = 961, 97*961 mod 1731 = 1474
    checks++; if (bus.o_prod !== 256'd1474) begin failures++; $display("FAIL mont_prod got=%0d exp=1474", bus.o_prod); end
  endtask

  task automatic test_start_ignored();
    int cyc; bit bok;
    start_job(256'd1731, 256'd100, 257'd200);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 49) begin
        bus.i_n     = 256'd97;
        bus.i_a     = 256'd3;
        bus.i_b     = 257'd5;
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;
    wait_end(cyc, bok);
    checks++; if (cyc + 50 !== 257) begin failures++; $display("FAIL ignore_latency got=%0d exp=257", cyc + 50); end
    checks++; if (bus.o_prod !== 256'd959) begin failures++; $display("FAIL ignore_prod got=%0d exp=959", bus.o_prod); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit bok;
    bit saw_end;
    start_job(256'd11, 256'd5, 257'd7);
    repeat (99) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_prod !== '0) begin failures++; $display("FAIL abort_prod got=%0d exp=0", bus.o_prod); end
    saw_end = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_end) saw_end = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_end) saw_end = 1'b1;
    end
    checks++; if (saw_end !== 1'b0) begin failures++; $display("FAIL abort_no_end got=%b exp=0", saw_end); end
    start_job(256'd13, 256'd12, 257'd12);
    wait_end(cyc, bok);
    checks++; if (cyc !== 257) begin failures++; $display("FAIL restart_latency got=%0d exp=257", cyc); end
    checks++; if (bus.o_prod !== 256'd1) begin failures++; $display("FAIL restart_prod got=%0d exp=1", bus.o_prod); end
  endtask

  task automatic test_back_to_back();
    int cyc1; int cyc2; bit bok;
    @(negedge clk);
    bus.i_n     = 256'd11;
    bus.i_a     = 256'd5;
    bus.i_b     = 257'd7;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_a = 256'd3;
    bus.i_b = 257'd4;
    wait_end(cyc1, bok);
    checks++; if (cyc1 !== 257) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=257", cyc1); end
    checks++; if (bus.o_prod !== 256'd2) begin failures++; $display("FAIL b2b_first_prod got=%0d exp=2", bus.o_prod); end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept got=%b exp=1", bus.o_busy); end
    checks++; if (bus.o_prod !== 256'd2) begin failures++; $display("FAIL b2b_prod_hold got=%0d exp=2", bus.o_prod); end
    wait_end(cyc2, bok);
    checks++; if (cyc2 + 1 !== 258) begin failures++; $display("FAIL b2b_period got=%0d exp=258", cyc2 + 1); end
    checks++; if (bus.o_prod !== 256'd1) begin failures++; $display("FAIL b2b_second_prod got=%0d exp=1", bus.o_prod); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_and_one();
    test_mont_domain();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
